// File: rtl/bcd_tracker_if.sv
// Tempo/display bus between the speed-adjust stage and the BCD tracker.
interface bcd_tracker_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] bin;
  logic [31:0]      data;
  logic             busy;
  logic             done;

  // Upstream side: drives the tempo value, observes the display word.
  modport master (
    output bin,
    input  data,
    input  busy,
    input  done
  );

  // Tracker side.
  modport slave (
    input  bin,
    output data,
    output busy,
    output done
  );
endinterface

// File: rtl/bcd_tracker.sv
// Tracks a binary tempo value and converts it to packed BCD with the
// shift-and-add-3 algorithm, one bit per cycle. A new conversion starts only
// when the input differs from the last captured value (or after reset), and
// the display word changes only at the end of a completed conversion.
module bcd_tracker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic          clk,
  input logic          rst_n,
  bcd_tracker_if.slave bus
);

  localparam int unsigned AccW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLoad
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  sr_q;
  logic [WIDTH-1:0]  last_bin_q;
  logic              primed_q;
  logic [CntW-1:0]   cnt_q;
  logic [AccW-1:0]   acc_q;
  logic [AccW-1:0]   acc_adj;
  logic [31:0]       data_q;
  logic              busy_q;
  logic              done_q;

  // Add 3 to every nibble >= 5 ahead of the shift; nibbles never exceed 9,
  // so the add cannot carry into the next digit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      last_bin_q <= '0;
      primed_q   <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!primed_q || (bus.bin != last_bin_q)) begin
            sr_q       <= bus.bin;
            last_bin_q <= bus.bin;
            primed_q   <= 1'b1;
            cnt_q      <= CntW'(WIDTH);
            acc_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          acc_q <= {acc_adj[AccW-2:0], sr_q[WIDTH-1]};
          sr_q  <= sr_q << 1;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          data_q  <= 32'(acc_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data = data_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bcd_tracker.sv
// Randomized and directed bench for bcd_tracker against a transaction-level
// model: a capture schedules a display update WIDTH+1 edges later.
module tb_bcd_tracker;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;

  bcd_tracker_if #(.WIDTH(WIDTH)) bus ();

  bcd_tracker #(
    .WIDTH (WIDTH),
    .DIGITS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state.
  bit          m_primed;
  int unsigned m_last;
  int unsigned m_val;
  int          m_left;
  logic [31:0] m_data;
  bit          m_busy;
  bit          m_done;
  int unsigned done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_primed = 1'b0;
    m_last   = 0;
    m_val    = 0;
    m_left   = 0;
    m_data   = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
  endtask

  // One clock: present bin, advance model at the edge, compare at negedge.
  task automatic step(input int unsigned b);
    int unsigned sampled;
    bus.bin = WIDTH'(b);
    @(posedge clk);
    sampled = b;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_data = to_bcd(m_val);
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (!m_primed || sampled != m_last) begin
      m_val    = sampled;
      m_last   = sampled;
      m_primed = 1'b1;
      m_left   = WIDTH + 1;
      m_busy   = 1'b1;
    end
    @(negedge clk);
    check("data", bus.data, m_data);
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    if (bus.done) done_seen++;
  endtask

  task automatic hold(input int unsigned b, input int unsigned cycles);
    for (int i = 0; i < int'(cycles); i++) step(b);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_data", bus.data, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned b;
    model_reset();
    done_seen = 0;
    rst_n     = 1'b0;
    bus.bin   = WIDTH'(120);
    repeat (3) @(negedge clk);
    check("reset_data", bus.data, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;

    // First conversion after release, then steady input.
    hold(120, 9);
    check("pre_done_data", bus.data, 32'h0);
    step(120);
    check("first_data", bus.data, 32'h0000_0120);
    check("first_done", 32'(bus.done), 32'h1);
    hold(120, 10);
    check("steady_no_done", done_seen, 1);

    // 120 -> 255.
    hold(255, 12);
    check("max_data", bus.data, 32'h0000_0255);

    // Input changes while busy: two conversions, final value shown.
    done_seen = 0;
    hold(100, 12);
    done_seen = 0;
    hold(101, 3);
    hold(102, 25);
    check("two_dones", done_seen, 2);
    check("mid_busy_data", bus.data, 32'h0000_0102);

    // Reset during SHIFT step 4 of bin=200.
    hold(200, 12);
    hold(100, 12);
    hold(200, 5);
    async_reset();
    hold(200, 12);
    check("post_reset_data", bus.data, 32'h0000_0200);

    // Reset with bin=0: first edge still converts.
    @(negedge clk);
    async_reset();
    hold(0, 12);
    check("zero_data", bus.data, 32'h0);

    // Full sweep.
    for (int v = 0; v < 256; v++) begin
      hold(v, 11);
      check("sweep", bus.data, to_bcd(v));
    end

    // Random changes, including ones landing mid-conversion.
    b = 37;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) b = $urandom_range(255);
      step(b);
    end
    hold(b, 25);
    check("rand_final", bus.data, to_bcd(b));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_tracker.md
BCD_TRACKER -- requirements
Module: bcd_tracker

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the binary tempo input.
REQ-002 Parameter DIGITS, default 3: number of BCD digits produced; shall satisfy 10^DIGITS > 2^WIDTH-1, with 4*DIGITS <= 32.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bin  input  WIDTH  binary tempo value from the speed-adjust stage; may change on any cycle.
REQ-006 data  output  32  display word for the seven-segment driver; data[4*DIGITS-1:0] = BCD digits, hundreds digit in the highest nibble; data[31:4*DIGITS] = 0.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse marking the cycle data is updated.

Function
REQ-009 FSM shall have exactly three states: IDLE, SHIFT, LOAD.
REQ-010 IDLE: on a rising edge with (bin != last_bin) or primed==0, capture bin into shift register, set last_bin<=bin, primed<=1, bit counter<=WIDTH, BCD accumulator<=0, go to SHIFT; otherwise stay in IDLE.
REQ-011 SHIFT: each edge, add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left one bit, decrement counter; go to LOAD on the edge where counter reaches 0 (exactly WIDTH SHIFT edges).
REQ-012 LOAD: one edge; data<=zero-extended accumulator, done<=1, busy<=0, return to IDLE.
REQ-013 done shall be high for exactly the one cycle following the LOAD edge; low otherwise.
REQ-014 busy shall be 1 from the capture edge up to the LOAD edge; 0 in IDLE.
REQ-015 Latency: data and done update on the (WIDTH+1)th rising edge after the capture edge (9 edges for WIDTH=8).
REQ-016 data shall hold its previous value throughout a conversion; no intermediate accumulator value shall appear on data.
REQ-017 Changes on bin while busy shall not affect the running conversion; they are picked up by the IDLE comparison on the edge after LOAD, so the last stable bin value is always eventually displayed.
REQ-018 bin constant and primed==1: no conversion, no done pulse, data stable indefinitely.
REQ-019 All arithmetic unsigned; nibble add-3 shall not carry across nibbles (nibble value <= 9 before shift guarantees this).
REQ-020 bin = 2^WIDTH-1 (255) shall produce data = 32'h0000_0255; bin = 0 shall produce 32'h0000_0000.

Reset
REQ-021 rst_n low shall immediately, regardless of clk, force: state=IDLE, data=0, busy=0, done=0, primed=0, last_bin=0, counter=0, accumulator=0, shift register=0.
REQ-022 Reset mid-conversion shall abandon it; data shall read 0 until the next completed conversion.
REQ-023 After rst_n releases, the first rising edge shall capture bin unconditionally (primed==0), so data reflects bin even when bin equals 0.

Verification
REQ-024 bin=120 held, rst_n released -> done pulses on the 10th edge after release, data=32'h0000_0120, busy high for edges 1..9.
REQ-025 Steady bin=120, then bin=255 -> data stays 0x120 for 8 cycles, becomes 0x255 with one done pulse 9 edges after capture.
REQ-026 bin 100->101, then ->102 three cycles later (mid-busy) -> done with data=0x101, then second conversion, final data=0x102; exactly two done pulses.
REQ-027 rst_n pulled low at SHIFT step 4 of bin=200 -> data, busy, done read 0 within the same cycle; after release data=0x200 following a full conversion.
REQ-028 Sweep bin 0..255, each held until done -> every data matches decimal digits of bin; data[31:12]==0 throughout; no done pulse while bin held constant.
